// File: rtl/page_read_sequencer.sv
// Read-side page walker: issues one req/ack page read per page of an inclusive,
// wrapping page range within a block, with abort, rd_err and ack-timeout handling.
module page_read_sequencer #(
   parameter int PAGE_BITS  = 6,
   parameter int BLOCK_BITS = 10,
   parameter int TIMEOUT    = 255
) (
   input  logic                            clk2,
   input  logic                            Reset,
   input  logic                            start,
   input  logic                            abort,
   input  logic [BLOCK_BITS-1:0]           block_addr,
   input  logic [PAGE_BITS-1:0]            start_page,
   input  logic [PAGE_BITS-1:0]            last_page,
   output logic                            rd_req,
   output logic [BLOCK_BITS+PAGE_BITS-1:0] rd_addr,
   input  logic                            rd_ack,
   input  logic                            rd_err,
   output logic [PAGE_BITS-1:0]            CurrentPage,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic                            timeout
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t                  state_r;
   logic [BLOCK_BITS-1:0]   blk_r;
   logic [PAGE_BITS-1:0]    last_r;
   logic [WAIT_W-1:0]       wait_r;
   logic [PAGE_BITS-1:0]    next_page_s;

   // Page increment wraps naturally at 2^PAGE_BITS.
   assign next_page_s = CurrentPage + PAGE_BITS'(1);

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk2) begin
      if (Reset) begin
         state_r     <= IDLE;
         blk_r       <= {BLOCK_BITS{1'b0}};
         last_r      <= {PAGE_BITS{1'b0}};
         wait_r      <= {WAIT_W{1'b0}};
         rd_req      <= 1'b0;
         rd_addr     <= {(BLOCK_BITS+PAGE_BITS){1'b0}};
         CurrentPage <= {PAGE_BITS{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  blk_r       <= block_addr;
                  last_r      <= last_page;
                  CurrentPage <= start_page;
                  rd_addr     <= {block_addr, start_page};
                  wait_r      <= {WAIT_W{1'b0}};
                  error       <= 1'b0;
                  timeout     <= 1'b0;
                  rd_req      <= 1'b1;
                  busy        <= 1'b1;
                  state_r     <= REQ;
               end
            end
            REQ: begin
               if (abort) begin
                  rd_req  <= 1'b0;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  if (rd_err || (CurrentPage == last_r)) begin
                     error   <= rd_err;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_r <= FIN;
                  end else begin
                     state_r <= GAP;
                  end
               end else if (wait_r == WAIT_LAST) begin
                  // Ack never came: rd_req has been high for exactly TIMEOUT cycles.
                  rd_req  <= 1'b0;
                  error   <= 1'b1;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= FIN;
               end else begin
                  wait_r <= wait_r + WAIT_W'(1);
               end
            end
            GAP: begin
               if (abort) begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  CurrentPage <= next_page_s;
                  rd_addr     <= {blk_r, next_page_s};
                  wait_r      <= {WAIT_W{1'b0}};
                  rd_req      <= 1'b1;
                  state_r     <= REQ;
               end
            end
            FIN: begin
               state_r <= IDLE;
            end
            default: begin
               rd_req  <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_page_read_sequencer.sv
// Directed self-checking bench for page_read_sequencer (TIMEOUT overridden to 4).
module tb_page_read_sequencer;

   logic        clk2 = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  block_addr = 10'd0;
   logic [5:0]  start_page = 6'd0;
   logic [5:0]  last_page = 6'd0;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic        rd_ack = 1'b0;
   logic        rd_err = 1'b0;
   logic [5:0]  CurrentPage;
   logic        busy;
   logic        done;
   logic        error;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   page_read_sequencer #(.PAGE_BITS(6), .BLOCK_BITS(10), .TIMEOUT(4)) dut (
      .clk2(clk2), .Reset(Reset), .start(start), .abort(abort),
      .block_addr(block_addr), .start_page(start_page), .last_page(last_page),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_err(rd_err),
      .CurrentPage(CurrentPage), .busy(busy), .done(done),
      .error(error), .timeout(timeout)
   );

   // 10 ns clock.
   always #5 clk2 = ~clk2;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   task automatic do_start(input logic [9:0] blk, input logic [5:0] sp, input logic [5:0] lp);
      block_addr = blk;
      start_page = sp;
      last_page  = lp;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   // Wait (bounded) for a request, check its address, ack it with the given rd_err.
   task automatic ack_once(input string tag, input logic [9:0] blk, input logic [5:0] pg,
                           input logic err);
      int n;
      n = 0;
      while (!rd_req && n < 10) begin
         tick();
         n++;
      end
      check_eq({tag, "_req"}, {31'd0, rd_req}, 32'd1);
      check_eq({tag, "_addr"}, {16'd0, rd_addr}, {16'd0, blk, pg});
      check_eq({tag, "_page"}, {26'd0, CurrentPage}, {26'd0, pg});
      rd_ack = 1'b1;
      rd_err = err;
      tick();
      rd_ack = 1'b0;
      rd_err = 1'b0;
   endtask

   // Run a full sequence of n pages from sp, optionally failing request err_idx.
   task automatic serve(input string tag, input logic [9:0] blk, input logic [5:0] sp,
                        input int n, input int err_idx);
      logic [5:0] pg;
      for (int i = 0; i < n; i++) begin
         pg = sp + 6'(i);
         ack_once(tag, blk, pg, (i == err_idx));
         if (i == n - 1 || i == err_idx) begin
            check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
            check_eq({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
            check_eq({tag, "_req_fin"}, {31'd0, rd_req}, 32'd0);
            break;
         end else begin
            check_eq({tag, "_gap_req"}, {31'd0, rd_req}, 32'd0);
            check_eq({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
            check_eq({tag, "_gap_done"}, {31'd0, done}, 32'd0);
         end
      end
      tick();
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_idle_req"}, {31'd0, rd_req}, 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req"}, {31'd0, rd_req}, 32'd0);
      check_eq({tag, "_addr"}, {16'd0, rd_addr}, 32'd0);
      check_eq({tag, "_page"}, {26'd0, CurrentPage}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_err"}, {31'd0, error}, 32'd0);
      check_eq({tag, "_tmo"}, {31'd0, timeout}, 32'd0);
   endtask

   initial begin
      int n;

      tick();
      tick();
      Reset = 1'b0;
      check_reset_vals("reset");

      // Basic run: block 5, pages 3..6.
      do_start(10'd5, 6'd3, 6'd6);
      check_eq("basic_req_n1", {31'd0, rd_req}, 32'd1);
      check_eq("basic_busy_n1", {31'd0, busy}, 32'd1);
      serve("basic", 10'd5, 6'd3, 4, -1);
      check_eq("basic_err", {31'd0, error}, 32'd0);
      check_eq("basic_busy", {31'd0, busy}, 32'd0);

      // Wrap 62,63,0,1 then a single-page run.
      do_start(10'd7, 6'd62, 6'd1);
      serve("wrap", 10'd7, 6'd62, 4, -1);
      do_start(10'd9, 6'd9, 6'd9);
      serve("single", 10'd9, 6'd9, 1, -1);

      // rd_err on the 2nd of 4 requests.
      do_start(10'd2, 6'd10, 6'd13);
      serve("rderr", 10'd2, 6'd10, 4, 1);
      check_eq("rderr_err", {31'd0, error}, 32'd1);
      check_eq("rderr_tmo", {31'd0, timeout}, 32'd0);
      tick();
      check_eq("rderr_no3rd", {31'd0, rd_req}, 32'd0);
      do_start(10'd2, 6'd20, 6'd20);
      check_eq("rderr_clear", {31'd0, error}, 32'd0);
      serve("rderr_again", 10'd2, 6'd20, 1, -1);

      // Timeout: never ack, rd_req high for exactly 4 cycles.
      do_start(10'd1, 6'd20, 6'd21);
      n = 0;
      while (rd_req && n < 20) begin
         n++;
         tick();
      end
      check_eq("tmo_cycles", n, 32'd4);
      check_eq("tmo_done", {31'd0, done}, 32'd1);
      check_eq("tmo_err", {31'd0, error}, 32'd1);
      check_eq("tmo_tmo", {31'd0, timeout}, 32'd1);
      tick();
      check_eq("tmo_done_pulse", {31'd0, done}, 32'd0);

      // Abort in GAP after page 3; a start mid-run is ignored.
      do_start(10'd3, 6'd1, 6'd6);
      check_eq("abort_clear_tmo", {31'd0, timeout}, 32'd0);
      block_addr = 10'd99;
      start_page = 6'd40;
      start = 1'b1;
      ack_once("abort_p1", 10'd3, 6'd1, 1'b0);
      start = 1'b0;
      ack_once("abort_p2", 10'd3, 6'd2, 1'b0);
      ack_once("abort_p3", 10'd3, 6'd3, 1'b0);
      check_eq("abort_in_gap", {31'd0, rd_req}, 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_req", {31'd0, rd_req}, 32'd0);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      check_eq("abort_page", {26'd0, CurrentPage}, 32'd3);
      tick();
      check_eq("abort_idle_req", {31'd0, rd_req}, 32'd0);
      check_eq("abort_idle_done", {31'd0, done}, 32'd0);

      // Reset while rd_req is high.
      do_start(10'd6, 6'd30, 6'd33);
      check_eq("rst_pre_req", {31'd0, rd_req}, 32'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check_reset_vals("rst_mid");

      // Back-to-back: start during done is ignored, accepted one cycle later.
      do_start(10'd4, 6'd0, 6'd0);
      ack_once("b2b_first", 10'd4, 6'd0, 1'b0);
      check_eq("b2b_done", {31'd0, done}, 32'd1);
      block_addr = 10'd8;
      start_page = 6'd5;
      last_page  = 6'd5;
      start      = 1'b1;
      tick();
      check_eq("b2b_ignored_req", {31'd0, rd_req}, 32'd0);
      check_eq("b2b_ignored_busy", {31'd0, busy}, 32'd0);
      tick();
      start = 1'b0;
      check_eq("b2b_req", {31'd0, rd_req}, 32'd1);
      check_eq("b2b_addr", {16'd0, rd_addr}, {16'd0, 10'd8, 6'd5});
      serve("b2b_second", 10'd8, 6'd5, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/page_read_sequencer.md
# page_read_sequencer

Read-side page walker for the flash block datapath. Given a block address and an inclusive page range, it issues one page-read request per page over a req/ack handshake and tracks the current page. Page numbers wrap modulo 2^PAGE_BITS, the same way the write side rolls over. It sits between the command controller (start/abort) and the flash read interface.

## Interface
- PAGE_BITS, 6, width of the page index (pages per block = 2^PAGE_BITS)
- BLOCK_BITS, 10, width of the block address
- TIMEOUT, 255, max cycles a request may wait for rd_ack before timing out (≥1)

- clk2  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  begin a sequence; honoured only when idle
- abort  in  1  cancel the running sequence
- block_addr  in  BLOCK_BITS  block to read; latched on start
- start_page  in  PAGE_BITS  first page; latched on start
- last_page  in  PAGE_BITS  final page, inclusive; latched on start
- rd_req  out  1  page-read request
- rd_addr  out  BLOCK_BITS+PAGE_BITS  {block, page}; stable while rd_req=1
- rd_ack  in  1  request accepted (meaningful only while rd_req=1)
- rd_err  in  1  read failed; sampled with rd_ack
- CurrentPage  out  PAGE_BITS  page currently requested or last requested
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence ends (success or error)
- error  out  1  sticky: last sequence failed
- timeout  out  1  sticky: failure was a timeout, not rd_err

## Operation
- States: IDLE, REQ, GAP, FIN.
- IDLE: rd_req=0, busy=0.
  - start=1 latches block_addr, start_page and last_page.
  - It clears error and timeout, loads CurrentPage=start_page, zeroes the wait counter and goes to REQ.
- REQ: rd_req=1, busy=1, rd_addr={blk, CurrentPage}. The wait counter increments each cycle.
  - rd_ack=1, rd_err=0, CurrentPage==last: go to FIN.
  - rd_ack=1, rd_err=0, CurrentPage!=last: go to GAP.
  - rd_ack=1, rd_err=1: set error and go to FIN.
  - No ack when the wait counter reaches TIMEOUT-1: set error and timeout, then go to FIN.
- GAP: rd_req=0, busy=1. CurrentPage <= CurrentPage+1 mod 2^PAGE_BITS, wait counter <= 0, then go to REQ.
- FIN: done=1 for this cycle, busy=0, rd_req=0, then go to IDLE.
- abort=1 in REQ or GAP: go to IDLE next cycle.
  - No done pulse; error and timeout are unchanged.
  - CurrentPage holds its value.
- start while not in IDLE is ignored. abort in IDLE or FIN is ignored.
- Wrap: start_page > last_page walks start..2^PAGE_BITS-1, then 0..last. start_page == last_page issues exactly one request.
- Page count is ((last-start) mod 2^PAGE_BITS)+1, maximum 2^PAGE_BITS.
- Reset is priority over all inputs and returns the block to IDLE from any state, including mid-handshake. rd_req drops the cycle after reset is sampled.

## Timing
- Reset values: rd_req=0, rd_addr=0, CurrentPage=0, busy=0, done=0, error=0, timeout=0, state IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- start sampled at edge N: rd_req=1 and busy=1 from cycle N+1.
- rd_ack sampled at edge K: rd_req=0 at K+1 (GAP), next request at K+2 with page+1. This gives one page per 2 cycles at best.
- Last page acked at edge K: done=1 during cycle K+1, busy=0 at K+1, IDLE at K+2. A new start is accepted from K+2.
- A new start may be presented in the cycle done is high but is not accepted until the next cycle.
- Timeout: with no ack, rd_req stays high for exactly TIMEOUT cycles, then done and error rise together.
- rd_addr and CurrentPage change only in GAP or on start, never while rd_req=1.

## Test plan
- Basic run: start, blk=5, start_page=3, last_page=6, ack every request 1 cycle after it rises.
  - Expect 4 requests with rd_addr {5,3},{5,4},{5,5},{5,6}.
  - Expect one done pulse, error=0, busy low after done.
- Wrap and single page: start=62, last=1 gives requests for pages 62,63,0,1. A second run with start=last=9 gives exactly one request, then done.
- Error: ack the 2nd of 4 requests with rd_err=1.
  - Expect done the next cycle, error=1, timeout=0 and no 3rd request.
  - error clears on the following start.
- Timeout: TIMEOUT=4, never ack. Expect rd_req high exactly 4 cycles, then done=1, error=1, timeout=1.
- Abort and reset: abort in GAP after page 3.
  - Expect rd_req=0, busy=0 and no done next cycle; a start during the run is ignored.
  - Repeat with Reset asserted while rd_req=1: all outputs return to reset values the next cycle.
- Back-to-back: present start in the cycle done is high, expecting it to be ignored. Present start one cycle later, expecting a new sequence with rd_req at +1.
